pio_shift_unit: RTL and testbench

Parametrised shift-register unit for a PIO state machine. One instance serves as the OSR (output shift, refilled from the TX FIFO) or the ISR (input shift, drained into the RX FIFO). The mode is selected at run time. The unit adds configurable data width, autopull/autopush thresholds with valid/ready FIFO handshakes, and stall generation. It sits between the instruction decoder (OUT/IN/PULL/PUSH/MOV) and the TX/RX FIFOs.

---
 rtl/pio_pkg.sv | 23 ++
 rtl/pio_shift_align.sv | 46 ++++
 rtl/pio_shift_unit.sv | 178 +++++++++++++++++
 tb/tb_pio_shift_unit.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pio_pkg.sv
// Shared definitions for the PIO shift unit.
//   - pio_mode_e : run-time mode encoding (OSR shift-out / ISR shift-in)
//   - pio_state_e: ISR push FSM states
//   - decode_count(): maps a raw count/threshold field where 0 means "full width"
package pio_pkg;

  typedef enum logic {
    PIO_MODE_OSR = 1'b0,
    PIO_MODE_ISR = 1'b1
  } pio_mode_e;

  typedef enum logic {
    IDLE      = 1'b0,
    PUSH_WAIT = 1'b1
  } pio_state_e;

  // A zero shift amount or threshold stands for a full-width operation.
  function automatic int unsigned decode_count(input int unsigned raw,
                                               input int unsigned data_w);
    return (raw == 0) ? data_w : raw;
  endfunction

endpackage

// File: rtl/pio_shift_align.sv
// Combinational bit alignment for the PIO shift unit.
// Given the current register, an ISR source word and a decoded shift amount
// n (1..DATA_W), produces for the selected direction:
//   extract  : the n bits leaving the register, LSB-aligned, zero-extended
//   osr_next : register after an output shift (vacated bits zero)
//   isr_next : register after an input shift (shift_in[n-1:0] inserted)
// Ports:
//   reg_in   in  DATA_W  current register contents
//   shift_in in  DATA_W  ISR source bits, LSB-aligned
//   n        in  N_W     decoded shift amount, never 0
//   dir      in  1       1 = right, 0 = left
module pio_shift_align #(
  parameter int DATA_W = 32,
  parameter int N_W    = $clog2(DATA_W) + 2
) (
  input  logic [DATA_W-1:0] reg_in,
  input  logic [DATA_W-1:0] shift_in,
  input  logic [N_W-1:0]    n,
  input  logic              dir,
  output logic [DATA_W-1:0] extract,
  output logic [DATA_W-1:0] osr_next,
  output logic [DATA_W-1:0] isr_next
);

  logic [N_W-1:0]    inv_n;     // DATA_W - n
  logic [DATA_W-1:0] mask;      // n low-order ones
  logic [DATA_W-1:0] src_bits;

  assign inv_n    = N_W'(DATA_W) - n;
  // Shifting an all-ones word right keeps the mask well defined for n = DATA_W.
  assign mask     = {DATA_W{1'b1}} >> inv_n;
  assign src_bits = shift_in & mask;

  always_comb begin
    if (dir) begin
      extract  = reg_in & mask;
      osr_next = reg_in >> n;
      isr_next = (reg_in >> n) | (src_bits << inv_n);
    end else begin
      extract  = reg_in >> inv_n;
      osr_next = reg_in << n;
      isr_next = (reg_in << n) | src_bits;
    end
  end

endmodule

// File: rtl/pio_shift_unit.sv
// PIO shift register unit, usable as OSR (shift out, refilled from TX FIFO)
// or ISR (shift in, drained into RX FIFO), selected at run time by mode.
// Optional feature macro: PIO_SHIFT_AUTO_EN enables autopull/autopush; when
// undefined auto_en is ignored, fifo_rready stays 0 and OSR never stalls.
// Ports:
//   clk, reset (sync, active-high), penable (clock enable)
//   mode, dir, auto_en, threshold        configuration (0 threshold = DATA_W)
//   shift_req, shift_n, shift_in         shift request (0 shift_n = DATA_W)
//   load, load_data, load_count          manual register load
//   push_req                             manual ISR push
//   shift_out, data, count, stall        status / shifted-out bits
//   fifo_rdata/rvalid/rready             TX FIFO pop side
//   fifo_wdata/wvalid/wready             RX FIFO push side
module pio_shift_unit
  import pio_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = $clog2(DATA_W) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              penable,
  input  logic              mode,
  input  logic              dir,
  input  logic              auto_en,
  input  logic [CNT_W-1:0]  threshold,
  input  logic              shift_req,
  input  logic [CNT_W-1:0]  shift_n,
  input  logic [DATA_W-1:0] shift_in,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic [CNT_W-1:0]  load_count,
  input  logic              push_req,
  output logic [DATA_W-1:0] shift_out,
  output logic [DATA_W-1:0] data,
  output logic [CNT_W-1:0]  count,
  output logic              stall,
  input  logic [DATA_W-1:0] fifo_rdata,
  input  logic              fifo_rvalid,
  output logic              fifo_rready,
  output logic [DATA_W-1:0] fifo_wdata,
  output logic              fifo_wvalid,
  input  logic              fifo_wready
);

  // Count arithmetic is one bit wider so count + n never wraps.
  localparam int W1 = CNT_W + 1;

  pio_state_e        state_q, state_d;
  logic [DATA_W-1:0] reg_q, reg_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic [W1-1:0]     n_dec;
  logic [W1-1:0]     thr_dec;
  logic [W1-1:0]     count_ext;
  logic [W1-1:0]     count_sum;
  logic [W1-1:0]     count_sat;
  logic [CNT_W-1:0]  load_cnt_clamped;
  logic              auto_act;
  logic              refill_need;
  logic              shift_accept;

  logic [DATA_W-1:0] extract;
  logic [DATA_W-1:0] osr_next;
  logic [DATA_W-1:0] isr_next;

`ifdef PIO_SHIFT_AUTO_EN
  assign auto_act = auto_en;
`else
  logic unused_auto_en;
  assign unused_auto_en = auto_en;
  assign auto_act       = 1'b0;
`endif

  assign n_dec     = W1'(decode_count(32'(shift_n), DATA_W));
  assign thr_dec   = W1'(decode_count(32'(threshold), DATA_W));
  assign count_ext = {1'b0, count_q};
  assign count_sum = count_ext + n_dec;
  assign count_sat = (count_sum > W1'(DATA_W)) ? W1'(DATA_W) : count_sum;

  assign load_cnt_clamped = ({1'b0, load_count} > W1'(DATA_W)) ? CNT_W'(DATA_W)
                                                               : load_count;

  // OSR is exhausted relative to the autopull threshold.
  assign refill_need = auto_act && (count_ext >= thr_dec);

  pio_shift_align #(
    .DATA_W (DATA_W),
    .N_W    (W1)
  ) u_align (
    .reg_in   (reg_q),
    .shift_in (shift_in),
    .n        (n_dec),
    .dir      (dir),
    .extract  (extract),
    .osr_next (osr_next),
    .isr_next (isr_next)
  );

  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    reg_d        = reg_q;
    count_d      = count_q;
    stall        = 1'b0;
    fifo_rready  = 1'b0;
    fifo_wvalid  = 1'b0;
    shift_accept = 1'b0;

    if (!reset) begin
      if (state_q == PUSH_WAIT) begin
        // Holding a word for the RX FIFO: everything else waits.
        stall       = shift_req | push_req | load;
        fifo_wvalid = penable;
        if (penable && fifo_wready) begin
          reg_d   = '0;
          count_d = '0;
          state_d = IDLE;
        end
      end else if (load) begin
        // Load wins over a concurrent shift; the shift is simply dropped.
        if (penable) begin
          reg_d   = load_data;
          count_d = load_cnt_clamped;
        end
      end else if (mode == PIO_MODE_OSR) begin
        if (refill_need) begin
          stall       = shift_req;
          fifo_rready = penable & fifo_rvalid;
          if (penable && fifo_rvalid) begin
            reg_d   = fifo_rdata;
            count_d = '0;
          end
        end else if (shift_req && penable) begin
          shift_accept = 1'b1;
          reg_d        = osr_next;
          count_d      = count_sat[CNT_W-1:0];
        end
      end else begin
        if (penable) begin
          if (shift_req) begin
            reg_d   = isr_next;
            count_d = count_sat[CNT_W-1:0];
            if (auto_act && (count_sat >= thr_dec)) begin
              state_d = PUSH_WAIT;
            end
          end
          // A manual push alongside a shift pushes the freshly shifted word.
          if (push_req) begin
            state_d = PUSH_WAIT;
          end
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      reg_q   <= '0;
      // An OSR starts empty (fully consumed); an ISR starts with nothing in it.
      count_q <= (mode == PIO_MODE_OSR) ? CNT_W'(DATA_W) : '0;
    end else begin
      state_q <= state_d;
      reg_q   <= reg_d;
      count_q <= count_d;
    end
  end

  assign shift_out  = shift_accept ? extract : '0;
  assign data       = reg_q;
  assign count      = count_q;
  assign fifo_wdata = reg_q;

endmodule

// File: tb/tb_pio_shift_unit.sv
// Directed testbench for pio_shift_unit: a 32-bit instance exercises OSR/ISR
// shifting, autopull/autopush (or their absence when PIO_SHIFT_AUTO_EN is
// undefined), saturation, load priority and reset in PUSH_WAIT; an 8-bit
// instance covers a narrow configuration.
module tb_pio_shift_unit;

  logic        clk = 1'b0;
  logic        reset;
  int          n_cmp = 0;
  int          n_bad = 0;

  // 32-bit instance
  logic        penable, mode, dir, auto_en, shift_req, load, push_req;
  logic [5:0]  threshold, shift_n, load_count;
  logic [31:0] shift_in, load_data, fifo_rdata;
  logic        fifo_rvalid, fifo_wready;
  logic [31:0] shift_out, data, fifo_wdata;
  logic [5:0]  count;
  logic        stall, fifo_rready, fifo_wvalid;

  // 8-bit instance
  logic        mode_8, dir_8, shift_req_8, load_8;
  logic [3:0]  shift_n_8, load_count_8;
  logic [7:0]  load_data_8;
  logic [7:0]  shift_out_8, data_8, fifo_wdata_8;
  logic [3:0]  count_8;
  logic        stall_8, fifo_rready_8, fifo_wvalid_8;

  always #5 clk = ~clk;

  pio_shift_unit #(.DATA_W(32)) u_dut32 (
    .clk         (clk),
    .reset       (reset),
    .penable     (penable),
    .mode        (mode),
    .dir         (dir),
    .auto_en     (auto_en),
    .threshold   (threshold),
    .shift_req   (shift_req),
    .shift_n     (shift_n),
    .shift_in    (shift_in),
    .load        (load),
    .load_data   (load_data),
    .load_count  (load_count),
    .push_req    (push_req),
    .shift_out   (shift_out),
    .data        (data),
    .count       (count),
    .stall       (stall),
    .fifo_rdata  (fifo_rdata),
    .fifo_rvalid (fifo_rvalid),
    .fifo_rready (fifo_rready),
    .fifo_wdata  (fifo_wdata),
    .fifo_wvalid (fifo_wvalid),
    .fifo_wready (fifo_wready)
  );

  pio_shift_unit #(.DATA_W(8)) u_dut8 (
    .clk         (clk),
    .reset       (reset),
    .penable     (1'b1),
    .mode        (mode_8),
    .dir         (dir_8),
    .auto_en     (1'b0),
    .threshold   (4'd0),
    .shift_req   (shift_req_8),
    .shift_n     (shift_n_8),
    .shift_in    (8'h00),
    .load        (load_8),
    .load_data   (load_data_8),
    .load_count  (load_count_8),
    .push_req    (1'b0),
    .shift_out   (shift_out_8),
    .data        (data_8),
    .count       (count_8),
    .stall       (stall_8),
    .fifo_rdata  (8'h00),
    .fifo_rvalid (1'b0),
    .fifo_rready (fifo_rready_8),
    .fifo_wdata  (fifo_wdata_8),
    .fifo_wvalid (fifo_wvalid_8),
    .fifo_wready (1'b0)
  );

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic m);
    mode  = m;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    fifo_rvalid = 1'b1;
    fifo_rdata  = 32'h1111_2222;
    auto_en     = 1'b1;
    shift_req   = 1'b1;
    mode        = 1'b0;
    mode_8      = 1'b0;
    reset       = 1'b1;
    tick();
    // Outputs forced quiet while reset is held.
    if (stall !== 1'b0) begin $display("FAIL rst_stall: got %b expected 0", stall); n_bad++; end
    n_cmp++;
    if (fifo_rready !== 1'b0) begin $display("FAIL rst_rready: got %b expected 0", fifo_rready); n_bad++; end
    n_cmp++;
    if (shift_out !== 32'h0) begin $display("FAIL rst_shift_out: got %h expected 0", shift_out); n_bad++; end
    n_cmp++;
    auto_en     = 1'b0;
    shift_req   = 1'b0;
    fifo_rvalid = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    if (data !== 32'h0) begin $display("FAIL rst_data: got %h expected 0", data); n_bad++; end
    n_cmp++;
    if (count !== 6'd32) begin $display("FAIL rst_count_osr: got %0d expected 32", count); n_bad++; end
    n_cmp++;
    if (count_8 !== 4'd8) begin $display("FAIL rst_count_w8: got %0d expected 8", count_8); n_bad++; end
    n_cmp++;
    if (fifo_wvalid !== 1'b0) begin $display("FAIL rst_wvalid: got %b expected 0", fifo_wvalid); n_bad++; end
    n_cmp++;
  endtask

  task automatic test_osr_shift();
    load       = 1'b1;
    load_data  = 32'hDEAD_BEEF;
    load_count = 6'd0;
    tick();
    load = 1'b0;
    if (data !== 32'hDEAD_BEEF) begin $display("FAIL osr_load: got %h expected deadbeef", data); n_bad++; end
    n_cmp++;
    shift_req = 1'b1;
    dir       = 1'b1;
    shift_n   = 6'd8;
    #1;
    if (shift_out !== 32'h0000_00EF) begin $display("FAIL osr_r8_out: got %h expected ef", shift_out); n_bad++; end
    n_cmp++;
    tick();
    if (count !== 6'd8) begin $display("FAIL osr_r8_count: got %0d expected 8", count); n_bad++; end
    n_cmp++;
    if (data !== 32'h00DE_ADBE) begin $display("FAIL osr_r8_data: got %h expected 00deadbe", data); n_bad++; end
    n_cmp++;
    dir     = 1'b0;
    shift_n = 6'd4;
    #1;
    if (shift_out !== 32'h0) begin $display("FAIL osr_l4_out: got %h expected 0", shift_out); n_bad++; end
    n_cmp++;
    tick();
    if (data !== 32'h0DEA_DBE0) begin $display("FAIL osr_l4_data: got %h expected 0deadbe0", data); n_bad++; end
    n_cmp++;
    if (count !== 6'd12) begin $display("FAIL osr_l4_count: got %0d expected 12", count); n_bad++; end
    n_cmp++;
    // Clock enable low: nothing moves.
    penable = 1'b0;
    tick();
    penable   = 1'b1;
    shift_req = 1'b0;
    if (data !== 32'h0DEA_DBE0 || count !== 6'd12) begin
      $display("FAIL osr_penable_hold: got %h/%0d expected 0deadbe0/12", data, count); n_bad++;
    end
    n_cmp++;
  endtask

  task automatic test_load_priority();
    load       = 1'b1;
    load_data  = 32'h5555_AAAA;
    load_count = 6'd3;
    shift_req  = 1'b1;
    dir        = 1'b1;
    shift_n    = 6'd8;
    #1;
    if (stall !== 1'b0) begin $display("FAIL ld_prio_stall: got %b expected 0", stall); n_bad++; end
    n_cmp++;
    if (shift_out !== 32'h0) begin $display("FAIL ld_prio_out: got %h expected 0", shift_out); n_bad++; end
    n_cmp++;
    tick();
    load      = 1'b0;
    shift_req = 1'b0;
    if (data !== 32'h5555_AAAA || count !== 6'd3) begin
      $display("FAIL ld_prio_reg: got %h/%0d expected 5555aaaa/3", data, count); n_bad++;
    end
    n_cmp++;
  endtask

  task automatic test_autopull();
    // Exhaust the OSR via a load with count 32.
    load       = 1'b1;
    load_data  = 32'h0;
    load_count = 6'd32;
    tick();
    load        = 1'b0;
    auto_en     = 1'b1;
    threshold   = 6'd0;
    shift_req   = 1'b1;
    shift_n     = 6'd0;
    dir         = 1'b1;
    fifo_rvalid = 1'b0;
`ifdef PIO_SHIFT_AUTO_EN
    for (int i = 0; i < 3; i++) begin
      #1;
      if (stall !== 1'b1 || fifo_rready !== 1'b0) begin
        $display("FAIL pull_empty_stall[%0d]: got stall=%b rready=%b expected 1/0", i, stall, fifo_rready); n_bad++;
      end
      n_cmp++;
      tick();
    end
    fifo_rvalid = 1'b1;
    fifo_rdata  = 32'h1234_5678;
    #1;
    if (fifo_rready !== 1'b1 || stall !== 1'b1) begin
      $display("FAIL pull_refill: got rready=%b stall=%b expected 1/1", fifo_rready, stall); n_bad++;
    end
    n_cmp++;
    tick();
    // Refill done: rready drops even though the FIFO still has data.
    if (fifo_rready !== 1'b0 || stall !== 1'b0) begin
      $display("FAIL pull_after: got rready=%b stall=%b expected 0/0", fifo_rready, stall); n_bad++;
    end
    n_cmp++;
    if (shift_out !== 32'h1234_5678) begin $display("FAIL pull_shift32: got %h expected 12345678", shift_out); n_bad++; end
    n_cmp++;
    tick();
    fifo_rvalid = 1'b0;
    if (data !== 32'h0 || count !== 6'd32) begin
      $display("FAIL pull_drained: got %h/%0d expected 0/32", data, count); n_bad++;
    end
    n_cmp++;
`else
    fifo_rvalid = 1'b1;
    fifo_rdata  = 32'h1234_5678;
    #1;
    if (fifo_rready !== 1'b0 || stall !== 1'b0) begin
      $display("FAIL noauto_pull: got rready=%b stall=%b expected 0/0", fifo_rready, stall); n_bad++;
    end
    n_cmp++;
    tick();
    fifo_rvalid = 1'b0;
`endif
    shift_req = 1'b0;
    auto_en   = 1'b0;
  endtask

  task automatic test_isr_autopush();
    do_reset(1'b1);
    auto_en   = 1'b1;
    threshold = 6'd8;
    dir       = 1'b0;
    shift_n   = 6'd4;
    shift_req = 1'b1;
    shift_in  = 32'hA;
    tick();
    if (fifo_wvalid !== 1'b0) begin $display("FAIL push_early: got %b expected 0", fifo_wvalid); n_bad++; end
    n_cmp++;
    shift_in = 32'h5;
    tick();
    shift_req = 1'b0;
`ifndef PIO_SHIFT_AUTO_EN
    if (fifo_wvalid !== 1'b0) begin $display("FAIL noauto_push: got %b expected 0", fifo_wvalid); n_bad++; end
    n_cmp++;
    push_req = 1'b1;
    tick();
    push_req = 1'b0;
`endif
    fifo_wready = 1'b0;
    shift_req   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (fifo_wvalid !== 1'b1 || fifo_wdata !== 32'hA5 || stall !== 1'b1) begin
        $display("FAIL push_wait[%0d]: got wvalid=%b wdata=%h stall=%b expected 1/a5/1",
                 i, fifo_wvalid, fifo_wdata, stall); n_bad++;
      end
      n_cmp++;
      tick();
    end
    shift_req   = 1'b0;
    fifo_wready = 1'b1;
    tick();
    fifo_wready = 1'b0;
    if (count !== 6'd0 || data !== 32'h0 || fifo_wvalid !== 1'b0) begin
      $display("FAIL push_done: got count=%0d data=%h wvalid=%b expected 0/0/0", count, data, fifo_wvalid); n_bad++;
    end
    n_cmp++;
    auto_en = 1'b0;
  endtask

  task automatic test_saturation();
    do_reset(1'b1);
    auto_en   = 1'b0;
    dir       = 1'b0;
    shift_n   = 6'd16;
    shift_req = 1'b1;
    shift_in  = 32'h1234; tick();
    shift_in  = 32'h5678; tick();
    shift_in  = 32'h9ABC; tick();
    shift_req = 1'b0;
    if (count !== 6'd32) begin $display("FAIL sat_count: got %0d expected 32", count); n_bad++; end
    n_cmp++;
    if (data !== 32'h5678_9ABC) begin $display("FAIL sat_data: got %h expected 56789abc", data); n_bad++; end
    n_cmp++;
    if (fifo_wvalid !== 1'b0) begin $display("FAIL sat_nopush: got %b expected 0", fifo_wvalid); n_bad++; end
    n_cmp++;
    shift_n   = 6'd0;
    shift_in  = 32'hCAFE_F00D;
    shift_req = 1'b1;
    tick();
    if (data !== 32'hCAFE_F00D || count !== 6'd32) begin
      $display("FAIL isr_full32: got %h/%0d expected cafef00d/32", data, count); n_bad++;
    end
    n_cmp++;
    dir      = 1'b1;
    shift_n  = 6'd8;
    shift_in = 32'hFFFF_FF11;
    tick();
    shift_req = 1'b0;
    if (data !== 32'h11CA_FEF0) begin $display("FAIL isr_right8: got %h expected 11cafef0", data); n_bad++; end
    n_cmp++;
  endtask

  task automatic test_reset_push_wait();
    do_reset(1'b1);
    fifo_wready = 1'b0;
    push_req    = 1'b1;
    tick();
    push_req = 1'b0;
    if (fifo_wvalid !== 1'b1) begin $display("FAIL manual_push: got %b expected 1", fifo_wvalid); n_bad++; end
    n_cmp++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    if (fifo_wvalid !== 1'b0) begin $display("FAIL rst_pw_wvalid: got %b expected 0", fifo_wvalid); n_bad++; end
    n_cmp++;
    shift_req = 1'b1;
    shift_n   = 6'd4;
    #1;
    if (stall !== 1'b0) begin $display("FAIL rst_pw_idle: got stall=%b expected 0", stall); n_bad++; end
    n_cmp++;
    shift_req = 1'b0;
    tick();
  endtask

  task automatic test_width8();
    load_8       = 1'b1;
    load_data_8  = 8'hB5;
    load_count_8 = 4'd0;
    tick();
    load_8      = 1'b0;
    shift_req_8 = 1'b1;
    dir_8       = 1'b1;
    shift_n_8   = 4'd3;
    #1;
    if (shift_out_8 !== 8'h05) begin $display("FAIL w8_out: got %h expected 05", shift_out_8); n_bad++; end
    n_cmp++;
    tick();
    shift_req_8 = 1'b0;
    if (data_8 !== 8'h16 || count_8 !== 4'd3) begin
      $display("FAIL w8_reg: got %h/%0d expected 16/3", data_8, count_8); n_bad++;
    end
    n_cmp++;
  endtask

  initial begin
    reset = 1'b1; penable = 1'b1; mode = 1'b0; dir = 1'b1; auto_en = 1'b0;
    threshold = '0; shift_req = 1'b0; shift_n = '0; shift_in = '0;
    load = 1'b0; load_data = '0; load_count = '0; push_req = 1'b0;
    fifo_rdata = '0; fifo_rvalid = 1'b0; fifo_wready = 1'b0;
    mode_8 = 1'b0; dir_8 = 1'b1; shift_req_8 = 1'b0; load_8 = 1'b0;
    shift_n_8 = '0; load_count_8 = '0; load_data_8 = '0;

    test_reset();
    test_osr_shift();
    test_load_priority();
    test_autopull();
    test_isr_autopush();
    test_saturation();
    test_reset_push_wait();
    test_width8();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
